ioctl_mem_loader: RTL and testbench

//  Upstream stage of main RAM: takes the host ioctl byte stream (ROM/BASIC image download) and writes it into the
//  8 KB main memory window through a small FIFO with backpressure. Arbitrates against CPU memory cycles.

---
 rtl/altair_pkg.sv | 5 +
 rtl/loader_fifo.sv | 47 ++++
 rtl/ioctl_mem_loader.sv | 127 ++++++++++++
 tb/tb_ioctl_mem_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/altair_pkg.sv
// Shared types and constants for the ioctl image loader.
package altair_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} loader_state_t;
  localparam int LOADER_ADDR_W = 13;
endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO buffering {address, byte} pairs between the host stream and RAM.
module loader_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ioctl_mem_loader.sv
// Streams a host ioctl image into the main RAM window, holding the CPU in reset while loading.
module ioctl_mem_loader
  import altair_pkg::*;
#(
  parameter int ADDR_WIDTH = LOADER_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  output logic                  ioctl_wait,
  input  logic                  mem_busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  cpu_hold,
  output logic                  rom_loaded,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic [7:0]            checksum
);
  localparam int FW = ADDR_WIDTH + 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_t          state, state_next;
  logic                   prev_download;
  logic                   armed;
  logic                   rise, fall;
  logic                   active, next_active;
  logic                   load_entry;
  logic                   wr_ok, in_window, push, wr_err, commit;
  logic [FW-1:0]          fifo_din, fifo_dout;
  logic [CW-1:0]          fifo_count, count_next;
  logic                   fifo_full, fifo_empty;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [7:0]             mem_data_q;

  // A rise only counts once download has been seen low since reset, so a
  // transfer interrupted by reset is not picked up again halfway through.
  assign rise        = ioctl_download && !prev_download && armed;
  assign fall        = !ioctl_download && prev_download;
  assign active      = (state == LOAD) || (state == DRAIN);
  assign next_active = (state_next == LOAD) || (state_next == DRAIN);
  assign load_entry  = rise && ((state == IDLE) || (state == DONE));

  assign wr_ok     = (state == LOAD) && ioctl_wr;
  assign in_window = (ioctl_addr[24:ADDR_WIDTH] == '0);
  assign push      = wr_ok && in_window && !fifo_full;
  assign wr_err    = wr_ok && (!in_window || fifo_full);
  assign commit    = active && !fifo_empty && !mem_busy;
  assign fifo_din  = {ioctl_addr[ADDR_WIDTH-1:0], ioctl_dout};

  assign count_next = load_entry ? '0 : fifo_count + CW'(push) - CW'(commit);

  loader_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (load_entry),
    .push  (push),
    .pop   (commit),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = LOAD;
      LOAD:    if (fall) state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = DONE;
      DONE:    if (rise) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // RAM write port is combinational so mem_we can never overlap mem_busy.
  assign mem_we   = commit;
  assign mem_addr = commit ? fifo_dout[FW-1:8] : mem_addr_q;
  assign mem_data = commit ? fifo_dout[7:0]    : mem_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      prev_download <= 1'b0;
      armed         <= 1'b0;
      cpu_hold      <= 1'b0;
      ioctl_wait    <= 1'b0;
      rom_loaded    <= 1'b0;
      load_error    <= 1'b0;
      byte_count    <= '0;
      checksum      <= '0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
    end else begin
      state         <= state_next;
      prev_download <= ioctl_download;
      armed         <= armed || !ioctl_download;
      cpu_hold      <= next_active;
      ioctl_wait    <= next_active && (count_next >= CW'(FIFO_DEPTH - 1));
      if (load_entry) begin
        rom_loaded <= 1'b0;
        load_error <= 1'b0;
        byte_count <= '0;
        checksum   <= '0;
      end else begin
        if (state == DRAIN && state_next == DONE) rom_loaded <= 1'b1;
        if (wr_err) load_error <= 1'b1;
        if (commit) begin
          if (byte_count != COUNT_MAX) byte_count <= byte_count + 1'b1;
          checksum   <= checksum + fifo_dout[7:0];
          mem_addr_q <= fifo_dout[FW-1:8];
          mem_data_q <= fifo_dout[7:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_ioctl_mem_loader.sv
// Directed bench for ioctl_mem_loader with a write scoreboard on the RAM port.
module tb_ioctl_mem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        mem_busy = 1'b0;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_hold;
  logic        rom_loaded;
  logic        load_error;
  logic [13:0] byte_count;
  logic [7:0]  checksum;

  int total = 0;
  int bad = 0;
  logic [20:0] sb [$];

  ioctl_mem_loader dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_busy       (mem_busy),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .cpu_hold       (cpu_hold),
    .rom_loaded     (rom_loaded),
    .load_error     (load_error),
    .byte_count     (byte_count),
    .checksum       (checksum)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we && !reset) begin
      check("we_while_busy", {31'd0, mem_busy}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_we", {19'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [20:0] e;
        e = sb.pop_front();
        check("mem_addr", {19'd0, mem_addr}, {19'd0, e[20:8]});
        check("mem_data", {24'd0, mem_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d, input bit expect_commit);
    int guard = 0;
    while (ioctl_wait && guard < 200) begin
      tick();
      guard++;
    end
    check("wait_bound", {31'd0, guard < 200}, 32'd1);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (expect_commit) sb.push_back({a[12:0], d});
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
    check("cpu_hold_start", {31'd0, cpu_hold}, 32'd1);
  endtask

  task automatic finish_dl();
    int guard = 0;
    ioctl_download = 1'b0;
    while (!rom_loaded && guard < 100) begin
      tick();
      guard++;
    end
    check("rom_loaded", {31'd0, rom_loaded}, 32'd1);
    check("cpu_hold_end", {31'd0, cpu_hold}, 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_outputs", {ioctl_wait, mem_we, cpu_hold, rom_loaded, load_error, byte_count, checksum}, 32'd0);
    check("rst_mem", {11'd0, mem_addr, mem_data}, 32'd0);

    // Test 1: 16-byte image, addr = data
    start_dl();
    for (int i = 0; i < 16; i++) send(25'(i), 8'(i), 1'b1);
    finish_dl();
    check("t1_count", {18'd0, byte_count}, 32'd16);
    check("t1_sum", {24'd0, checksum}, 32'h78);

    // Test 2: RAM busy for 20 cycles during a burst
    start_dl();
    fork
      begin
        mem_busy = 1'b1;
        repeat (20) tick();
        mem_busy = 1'b0;
      end
      begin
        send(25'h100, 8'hA0, 1'b1);
        send(25'h101, 8'hA1, 1'b1);
        check("t2_wait_low", {31'd0, ioctl_wait}, 32'd0);
        send(25'h102, 8'hA2, 1'b1);
        check("t2_wait_high", {31'd0, ioctl_wait}, 32'd1);
        check("t2_no_commit", {18'd0, byte_count}, 32'd0);
        send(25'h103, 8'hA3, 1'b1);
        send(25'h104, 8'hA4, 1'b1);
        send(25'h105, 8'hA5, 1'b1);
      end
    join
    finish_dl();
    check("t2_count", {18'd0, byte_count}, 32'd6);
    check("t2_sum", {24'd0, checksum}, 32'hCF);
    check("t2_err", {31'd0, load_error}, 32'd0);

    // Test 3: out-of-window byte
    start_dl();
    send(25'h1FFE, 8'h11, 1'b1);
    send(25'h2000, 8'h22, 1'b0);
    send(25'h1FFF, 8'h33, 1'b1);
    finish_dl();
    check("t3_err", {31'd0, load_error}, 32'd1);
    check("t3_count", {18'd0, byte_count}, 32'd2);
    check("t3_sum", {24'd0, checksum}, 32'h44);

    // Test 5: back-to-back downloads
    start_dl();
    check("t5_clr_loaded", {31'd0, rom_loaded}, 32'd0);
    check("t5_clr_err", {31'd0, load_error}, 32'd0);
    for (int i = 0; i < 3; i++) send(25'(i), 8'(i + 1), 1'b1);
    finish_dl();
    start_dl();
    check("t5_clr_loaded2", {31'd0, rom_loaded}, 32'd0);
    check("t5_clr_count", {18'd0, byte_count}, 32'd0);
    check("t5_clr_sum", {24'd0, checksum}, 32'd0);
    send(25'd5, 8'h10, 1'b1);
    send(25'd6, 8'h20, 1'b1);
    finish_dl();
    check("t5_count", {18'd0, byte_count}, 32'd2);
    check("t5_sum", {24'd0, checksum}, 32'h30);

    // Test 6: strobe with download low
    send(25'd7, 8'h55, 1'b0);
    repeat (4) tick();
    check("t6_hold", {31'd0, cpu_hold}, 32'd0);
    check("t6_loaded", {31'd0, rom_loaded}, 32'd1);
    check("t6_count", {18'd0, byte_count}, 32'd2);

    // Test 4: reset after 5 of 10 bytes
    start_dl();
    for (int i = 0; i < 5; i++) send(25'(16 + i), 8'(i + 8'h40), 1'b1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("t4_rst_outputs", {ioctl_wait, mem_we, cpu_hold, rom_loaded, load_error, byte_count, checksum}, 32'd0);
    check("t4_rst_mem", {11'd0, mem_addr, mem_data}, 32'd0);
    reset = 1'b0;
    sb.delete();
    for (int i = 5; i < 10; i++) send(25'(16 + i), 8'(i + 8'h40), 1'b0);
    repeat (4) tick();
    check("t4_ignored_hold", {31'd0, cpu_hold}, 32'd0);
    check("t4_ignored_count", {18'd0, byte_count}, 32'd0);
    ioctl_download = 1'b0;
    tick();
    start_dl();
    check("t4_restart_count", {18'd0, byte_count}, 32'd0);
    send(25'd30, 8'h01, 1'b1);
    send(25'd31, 8'h02, 1'b1);
    finish_dl();
    check("t4_count", {18'd0, byte_count}, 32'd2);
    check("t4_sum", {24'd0, checksum}, 32'h03);

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
